// File: rtl/median_pkg.sv
// Shared constants for the median filter front end: default geometry and 3x3 tap layout.
package median_pkg;

    localparam int unsigned DEFAULT_IMG_W = 128;
    localparam int unsigned DEFAULT_IMG_H = 128;
    localparam int unsigned DEFAULT_PIX_W = 8;

    // Tap k = 3*dy + dx; row dy=0 is the line above the centre.
    localparam int unsigned TAP_TL = 0;
    localparam int unsigned TAP_T  = 1;
    localparam int unsigned TAP_TR = 2;
    localparam int unsigned TAP_L  = 3;
    localparam int unsigned TAP_C  = 4;
    localparam int unsigned TAP_R  = 5;
    localparam int unsigned TAP_BL = 6;
    localparam int unsigned TAP_B  = 7;
    localparam int unsigned TAP_BR = 8;

    localparam int unsigned NUM_TAPS = 9;
    localparam int unsigned WIN_W    = NUM_TAPS * DEFAULT_PIX_W;

    function automatic int tap_idx(input int dy, input int dx);
        return 3 * dy + dx;
    endfunction

endpackage

// File: rtl/median_line_buffer.sv
// One raster line of pixel storage: circular RAM with a shared read/write address.
module median_line_buffer #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned PIX_W = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    // Asynchronous read returns the old word, so a same-cycle write is read-before-write.
    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/median_window_gen.sv
// Raster pixel stream to registered, edge-replicated 3x3 windows for the median network.
module median_window_gen
    import median_pkg::*;
#(
    parameter int unsigned IMG_W = DEFAULT_IMG_W,
    parameter int unsigned IMG_H = DEFAULT_IMG_H,
    parameter int unsigned PIX_W = DEFAULT_PIX_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_frame_sync_in,
    input  logic [PIX_W-1:0]          io_data_in,
    output logic                      io_frame_sync_out,
    output logic                      io_valid_out,
    output logic [NUM_TAPS*PIX_W-1:0] io_window_out
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned DW = $clog2(IMG_W + 2);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [DW-1:0] DLY_INIT = DW'(IMG_W + 1);

    // Input side
    logic          r_in_act;
    logic [CW-1:0] r_in_col;
    logic          w_in_en;
    logic [CW-1:0] w_col;

    assign w_in_en = io_frame_sync_in | r_in_act;
    assign w_col   = io_frame_sync_in ? '0 : r_in_col;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_act <= 1'b0;
            r_in_col <= '0;
        end else if (w_in_en) begin
            r_in_act <= 1'b1;
            r_in_col <= (w_col == COL_LAST) ? '0 : w_col + CW'(1);
        end
    end

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic [PIX_W-1:0] w_lb0;
    logic [PIX_W-1:0] w_lb1;

    median_line_buffer #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (w_in_en),
        .i_addr  (w_col),
        .i_wdata (io_data_in),
        .o_rdata (w_lb0)
    );

    median_line_buffer #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (w_in_en),
        .i_addr  (w_col),
        .i_wdata (w_lb0),
        .o_rdata (w_lb1)
    );

    // 3x3 shift window; column dx=2 is the newest, row dy=2 the current input row.
    logic [PIX_W-1:0] r_win [3][3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int dy = 0; dy < 3; dy++) begin
                for (int dx = 0; dx < 3; dx++) begin
                    r_win[dy][dx] <= '0;
                end
            end
        end else begin
            for (int dy = 0; dy < 3; dy++) begin
                r_win[dy][0] <= r_win[dy][1];
                r_win[dy][1] <= r_win[dy][2];
            end
            r_win[0][2] <= w_lb1;
            r_win[1][2] <= w_lb0;
            r_win[2][2] <= io_data_in;
        end
    end

    // The window centred on (0,0) is complete IMG_W+1 edges after the sync pixel.
    logic          r_dly_act;
    logic [DW-1:0] r_dly;
    logic          w_start;

    assign w_start = r_dly_act && (r_dly == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dly_act <= 1'b0;
            r_dly     <= '0;
        end else if (io_frame_sync_in) begin
            r_dly_act <= 1'b1;
            r_dly     <= DLY_INIT;
        end else if (r_dly_act) begin
            if (r_dly == '0) begin
                r_dly_act <= 1'b0;
            end else begin
                r_dly <= r_dly - DW'(1);
            end
        end
    end

    // Output position tracker: position of the window about to be registered.
    logic          r_valid;
    logic [CW-1:0] r_ocol;
    logic [RW-1:0] r_orow;
    logic [CW-1:0] w_cur_col;
    logic [RW-1:0] w_cur_row;

    assign w_cur_col = w_start ? '0 : r_ocol;
    assign w_cur_row = w_start ? '0 : r_orow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ocol <= '0;
            r_orow <= '0;
        end else if (w_start || r_valid) begin
            if (w_cur_col == COL_LAST) begin
                r_ocol <= '0;
                r_orow <= (w_cur_row == ROW_LAST) ? '0 : w_cur_row + RW'(1);
            end else begin
                r_ocol <= w_cur_col + CW'(1);
                r_orow <= w_cur_row;
            end
        end
    end

    // Edge replication: out-of-frame taps take the centre row/column instead.
    logic [NUM_TAPS*PIX_W-1:0] w_win;

    always_comb begin
        int sy;
        int sx;
        w_win = '0;
        sy    = 0;
        sx    = 0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                sy = dy;
                sx = dx;
                if (dy == 0 && w_cur_row == '0)      sy = 1;
                if (dy == 2 && w_cur_row == ROW_LAST) sy = 1;
                if (dx == 0 && w_cur_col == '0)      sx = 1;
                if (dx == 2 && w_cur_col == COL_LAST) sx = 1;
                w_win[tap_idx(dy, dx)*PIX_W +: PIX_W] = r_win[sy][sx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_window_out     <= '0;
            io_frame_sync_out <= 1'b0;
            r_valid           <= 1'b0;
        end else begin
            io_window_out     <= w_win;
            io_frame_sync_out <= w_start;
            r_valid           <= r_valid | w_start;
        end
    end

    assign io_valid_out = r_valid;

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen: ramp, back-to-back, early sync, reset and random frames.
module tb_median_window_gen;

    localparam int W    = 128;
    localparam int H    = 128;
    localparam int NPIX = W * H;
    localparam int LAT  = W + 2;
    localparam int MAXS = 50000;

    localparam logic [71:0] HAND_5_5 =
        {8'h06, 8'h05, 8'h04, 8'h86, 8'h85, 8'h84, 8'h06, 8'h05, 8'h04};
    localparam logic [71:0] HAND_0_0 =
        {8'h81, 8'h80, 8'h80, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    localparam logic [71:0] HAND_127_127 =
        {8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'h7F, 8'h7F, 8'h7E};

    logic        clk = 1'b0;
    logic        reset;
    logic        sync_in;
    logic [7:0]  data_in;
    logic        sync_out;
    logic        valid_out;
    logic [71:0] win_out;

    always #5 clk = ~clk;

    median_window_gen dut (
        .clk               (clk),
        .reset             (reset),
        .io_frame_sync_in  (sync_in),
        .io_data_in        (data_in),
        .io_frame_sync_out (sync_out),
        .io_valid_out      (valid_out),
        .io_window_out     (win_out)
    );

    int         n_vec;
    int         n_bad;
    int         k;
    int         first_sync;
    int         rst_step;
    bit         in_rst;
    int         hist_code [MAXS];
    bit         hist_s    [MAXS];
    logic [7:0] rnd_img   [NPIX];

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", tag, k, got, exp);
        end
    endtask

    // ty 0: ramp, 1: constant AA, 2: random image
    function automatic logic [7:0] pix(input int ty, input int r, input int c);
        case (ty)
            0:       return 8'((r * W + c) & 255);
            1:       return 8'hAA;
            default: return rnd_img[r * W + c];
        endcase
    endfunction

    function automatic logic [71:0] model(input int ty, input int r, input int c);
        logic [71:0] v;
        int rr;
        int cc;
        v = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                rr = r + dy - 1;
                cc = c + dx - 1;
                if (rr < 0) rr = 0;
                if (rr > H - 1) rr = H - 1;
                if (cc < 0) cc = 0;
                if (cc > W - 1) cc = W - 1;
                v[(3 * dy + dx) * 8 +: 8] = pix(ty, rr, cc);
            end
        end
        return v;
    endfunction

    task automatic check_step();
        int   j;
        int   ty;
        int   p;
        logic exp_sync;
        logic exp_valid;
        j         = k - LAT;
        exp_sync  = (j >= rst_step) && hist_s[j];
        exp_valid = (first_sync >= 0) && (k >= first_sync + LAT);
        check("sync", {71'd0, sync_out}, {71'd0, exp_sync});
        check("valid", {71'd0, valid_out}, {71'd0, exp_valid});
        if (j >= rst_step && hist_code[j] >= 0) begin
            ty = hist_code[j] / 65536;
            p  = hist_code[j] % 65536;
            check("win", win_out, model(ty, p / W, p % W));
            if (ty == 0 && p == 5 * W + 5) check("win_5_5", win_out, HAND_5_5);
            if (ty == 0 && p == 0) check("win_0_0", win_out, HAND_0_0);
            if (ty == 0 && p == NPIX - 1) check("win_127_127", win_out, HAND_127_127);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_win"}, win_out, '0);
        check({tag, "_sync"}, {71'd0, sync_out}, '0);
        check({tag, "_valid"}, {71'd0, valid_out}, '0);
    endtask

    // One pixel per call; code = ty*65536 + pos for windows to verify, -1 otherwise.
    task automatic drive(input logic s, input logic [7:0] d, input int code);
        sync_in      = s;
        data_in      = d;
        hist_code[k] = code;
        hist_s[k]    = s;
        if (s && !in_rst && first_sync < 0) first_sync = k;
        @(posedge clk);
        #1;
        if (in_rst) check_zero("rst_hold");
        else        check_step();
        k++;
    endtask

    task automatic stream(input int ty, input int npix, input int nchk);
        for (int p = 0; p < npix; p++) begin
            drive(p == 0, pix(ty, p / W, p % W), (p < nchk) ? ty * 65536 + p : -1);
        end
    endtask

    task automatic do_reset(input int n);
        reset  = 1'b0;
        in_rst = 1'b1;
        #1;
        check_zero("rst_now");
        for (int i = 0; i < n; i++) drive(1'b0, 8'h5A, -1);
        reset      = 1'b1;
        in_rst     = 1'b0;
        first_sync = -1;
        rst_step   = k;
    endtask

    initial begin
        reset      = 1'b1;
        sync_in    = 1'b0;
        data_in    = '0;
        n_vec      = 0;
        n_bad      = 0;
        k          = 0;
        first_sync = -1;
        rst_step   = 0;
        in_rst     = 1'b0;
        for (int i = 0; i < NPIX; i++) rnd_img[i] = 8'($urandom);
        #2;
        do_reset(3);
        // Pre-sync pixels must be ignored.
        repeat (5) drive(1'b0, 8'h33, -1);
        stream(0, NPIX, NPIX);
        // Back-to-back AA frame, cut short by an early sync at pixel 5000.
        stream(1, 5000, 4800);
        stream(0, 3000, 2800);
        do_reset(3);
        for (int i = 0; i < 300; i++) drive(1'b0, pix(0, i / W, i % W), -1);
        stream(2, NPIX, NPIX);
        repeat (LAT + 10) drive(1'b0, 8'($urandom), -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
